// File: rtl/rob_committer.sv
// rob_committer: reorder buffer with in-order commit.
//
// Instructions are dispatched in program order and receive a tag {epoch, index}.
// Functional units return results out of order, tagged. The head entry commits once it
// is done and every output handshake it needs has completed. A redirecting or trapping
// commit flushes the whole buffer and toggles the epoch so that in-flight results
// carrying the old epoch are dropped.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   disp_valid_i / disp_ready_o  dispatch handshake; disp_rd_i, disp_pc_i payload
//   disp_tag_o                   tag allocated to the dispatching instruction
//   fu_*_i                       NUM_FU flattened result ports (tag, data, redirect, trap)
//   wb_valid_o / wb_ready_i      register-file write of wb_rd_o / wb_data_o
//   pcg_valid_o / pcg_ready_i    redirect of the PC generator to pcg_pc_o
//   trap_valid_o                 one-cycle trap-entry pulse with trap_pc_o, trap_cause_o
module rob_committer #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned XLEN   = 32,
  localparam int unsigned IW    = $clog2(DEPTH),
  localparam int unsigned TW    = IW + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   disp_valid_i,
  output logic                   disp_ready_o,
  input  logic [4:0]             disp_rd_i,
  input  logic [XLEN-1:0]        disp_pc_i,
  output logic [TW-1:0]          disp_tag_o,

  input  logic [NUM_FU-1:0]      fu_valid_i,
  input  logic [NUM_FU*TW-1:0]   fu_tag_i,
  input  logic [NUM_FU*XLEN-1:0] fu_result_i,
  input  logic [NUM_FU-1:0]      fu_redirect_i,
  input  logic [NUM_FU*XLEN-1:0] fu_new_pc_i,
  input  logic [NUM_FU-1:0]      fu_trap_i,
  input  logic [NUM_FU*5-1:0]    fu_cause_i,

  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic [XLEN-1:0]        wb_data_o,

  output logic                   pcg_valid_o,
  input  logic                   pcg_ready_i,
  output logic [XLEN-1:0]        pcg_pc_o,

  output logic                   trap_valid_o,
  output logic [XLEN-1:0]        trap_pc_o,
  output logic [4:0]             trap_cause_o
);

  localparam logic [IW:0]   DepthCnt = (IW + 1)'(DEPTH);
  localparam logic [IW-1:0] PtrOne   = IW'(1);
  localparam logic [IW:0]   CntOne   = (IW + 1)'(1);

  // Control state (reset)
  logic [IW-1:0]    head_q, head_d;
  logic [IW-1:0]    tail_q, tail_d;
  logic [IW:0]      count_q, count_d;
  logic             epoch_q, epoch_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;

  // Entry payload (qualified by busy/done, so not reset)
  logic [4:0]       rd_q       [DEPTH];
  logic [XLEN-1:0]  pc_q       [DEPTH];
  logic [XLEN-1:0]  result_q   [DEPTH];
  logic [XLEN-1:0]  new_pc_q   [DEPTH];
  logic             redirect_q [DEPTH];
  logic             trap_q     [DEPTH];
  logic [4:0]       cause_q    [DEPTH];

  logic [IW-1:0]    fu_idx     [NUM_FU];
  logic [NUM_FU-1:0] fu_accept;

  logic cand;
  logic head_redirect;
  logic head_trap;
  logic commit_fire;
  logic flush;
  logic disp_fire;

  // ---------------------------------------------------------------------------
  // Result acceptance: only the current epoch, and only an entry still waiting.
  // Entries freed by reset or flush have busy = 0, which drops late results.
  // ---------------------------------------------------------------------------
  always_comb begin
    fu_accept = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_idx[i]    = fu_tag_i[i*TW +: IW];
      fu_accept[i] = fu_valid_i[i] && (fu_tag_i[i*TW + IW] == epoch_q) &&
                     busy_q[fu_idx[i]] && !done_q[fu_idx[i]];
    end
  end

  // ---------------------------------------------------------------------------
  // Head / commit logic. Outputs come straight from the registered head entry,
  // which is not modified until it commits, so they hold steady under backpressure.
  // Gated by rst_i so nothing is presented while reset is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_redirect = redirect_q[head_q];
    head_trap     = trap_q[head_q];
    cand          = !rst_i && busy_q[head_q] && done_q[head_q];

    wb_valid_o    = cand && !head_trap && (rd_q[head_q] != 5'd0);
    wb_rd_o       = rd_q[head_q];
    wb_data_o     = result_q[head_q];

    pcg_valid_o   = cand && (head_redirect || head_trap);
    pcg_pc_o      = new_pc_q[head_q];

    commit_fire   = cand && (!wb_valid_o || wb_ready_i) && (!pcg_valid_o || pcg_ready_i);
    flush         = commit_fire && (head_redirect || head_trap);

    trap_valid_o  = commit_fire && head_trap;
    trap_pc_o     = pc_q[head_q];
    trap_cause_o  = cause_q[head_q];

    // count_q is the pre-commit occupancy, so a same-cycle commit frees nothing
    disp_ready_o  = !rst_i && (count_q < DepthCnt) && !flush;
    disp_tag_o    = {epoch_q, tail_q};
    disp_fire     = disp_valid_i && disp_ready_o;
  end

  // ---------------------------------------------------------------------------
  // Next-state for pointers, occupancy, epoch and per-entry flags.
  // A dispatching entry (tail) is never busy, so it cannot collide with an
  // accepted result; the committing entry (head) is done, so it cannot either.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    epoch_d = epoch_q;
    busy_d  = busy_q;
    done_d  = done_q;

    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_accept[i]) begin
        done_d[fu_idx[i]] = 1'b1;
      end
    end

    if (disp_fire) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + PtrOne;
    end

    if (flush) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      epoch_d = ~epoch_q;
    end else begin
      if (commit_fire) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + PtrOne;
      end
      if (disp_fire && !commit_fire) begin
        count_d = count_q + CntOne;
      end else if (!disp_fire && commit_fire) begin
        count_d = count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      epoch_q <= 1'b0;
      busy_q  <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      epoch_q <= epoch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Payload capture
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_accept[i]) begin
        result_q[fu_idx[i]]   <= fu_result_i[i*XLEN +: XLEN];
        new_pc_q[fu_idx[i]]   <= fu_new_pc_i[i*XLEN +: XLEN];
        redirect_q[fu_idx[i]] <= fu_redirect_i[i];
        trap_q[fu_idx[i]]     <= fu_trap_i[i];
        cause_q[fu_idx[i]]    <= fu_cause_i[i*5 +: 5];
      end
    end
    if (disp_fire) begin
      rd_q[tail_q] <= disp_rd_i;
      pc_q[tail_q] <= disp_pc_i;
    end
  end

endmodule

// File: doc/rob_committer.md
ROB_COMMITTER -- requirements
Module: rob_committer

Interface
REQ-001 Parameter NUM_FU, 4, number of functional-unit result ports (2..8).
REQ-002 Parameter DEPTH, 8, reorder-buffer entries, power of two (2..32).
REQ-003 Parameter XLEN, 32, data/PC width; IW = log2(DEPTH); TW = IW+1 (tag = {epoch, index}).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 disp_valid/disp_ready  in/out  1/1  dispatch handshake, in program order.
REQ-007 disp_rd, disp_pc  in  5, XLEN  destination register (0 = none), instruction PC.
REQ-008 disp_tag  out  TW  tag allocated to the dispatching instruction, valid with disp_ready.
REQ-009 fu_valid  in  NUM_FU  per-FU result strobe; no backpressure.
REQ-010 fu_tag, fu_result  in  NUM_FU*TW, NUM_FU*XLEN  per-FU tag and writeback data.
REQ-011 fu_redirect, fu_new_pc  in  NUM_FU, NUM_FU*XLEN  taken branch/jump/xret and target.
REQ-012 fu_trap, fu_cause  in  NUM_FU, NUM_FU*5  exception flag and cause code.
REQ-013 wb_valid/wb_ready, wb_rd, wb_data  out/in, out, out  1/1, 5, XLEN  register-file write.
REQ-014 pcg_valid/pcg_ready, pcg_pc  out/in, out  1/1, XLEN  redirect to PC generator.
REQ-015 trap_valid, trap_pc, trap_cause  out  1, XLEN, 5  CSR trap-entry pulse at commit.

Function
REQ-016 Circular buffer, head/tail IW-bit pointers, count 0..DEPTH, 1-bit epoch; index wraps DEPTH-1 -> 0.
REQ-017 disp_ready = (count < DEPTH) && !flush; a commit in the same cycle does not free a slot for that cycle's dispatch.
REQ-018 Dispatch accept: entry[tail] <= {busy=1, done=0, rd, pc}, disp_tag = {epoch, tail}, tail++, count++.
REQ-019 FU result accepted only if tag epoch == epoch and entry busy and not done; otherwise silently dropped.
REQ-020 Accepted result registers result, redirect, new_pc, trap, cause and sets done; several FUs with distinct tags may complete in one cycle.
REQ-021 Commit candidate = head entry with busy && done; result-to-commit latency minimum 1 cycle.
REQ-022 wb_valid = candidate && !trap && rd != 0; wb_rd/wb_data from head entry.
REQ-023 pcg_valid = candidate && (redirect || trap); pcg_pc = new_pc, or trap vector input ignored here: new_pc is supplied by FU for traps too.
REQ-024 Commit fires when candidate && (!wb_valid || wb_ready) && (!pcg_valid || pcg_ready); at most one commit per cycle, strictly in order.
REQ-025 Candidate with rd == 0 and no redirect/trap commits without any output handshake.
REQ-026 trap_valid = commit fire && trap, with trap_pc = entry pc, trap_cause = entry cause; single-cycle pulse.
REQ-027 Commit without redirect/trap: busy cleared, head++, count-- (net count unchanged if dispatch accepted same cycle).
REQ-028 flush = commit fire && (redirect || trap): all entries busy cleared, head = tail = 0, count = 0, epoch toggles; dispatch blocked that cycle.
REQ-029 Trapping instruction never writes rd; redirecting instruction writes rd if rd != 0 (same cycle as pcg).
REQ-030 Outputs stable while valid && !ready (AXI-stream rule); head entry not altered until commit.

Reset
REQ-031 On rst: head = tail = 0, count = 0, epoch = 0, all busy/done = 0.
REQ-032 During and after reset cycle: wb_valid = pcg_valid = trap_valid = 0; disp_ready = 1 from first cycle after rst deasserts.
REQ-033 Reset mid-operation discards all in-flight entries; late FU results carry stale state and are dropped only via busy = 0.

Verification
REQ-034 Out-of-order completion: dispatch tags 0,1,2 (rd 5,6,7); FU results for 2,0,1 -> wb writes rd5, rd6, rd7 in that order.
REQ-035 Full: DEPTH=8, dispatch 8 without results -> disp_ready = 0; complete tag 0, commit -> disp_ready = 1 next cycle, new tag = {0,0}.
REQ-036 Branch flush: tags 0..3 dispatched, tag 1 redirect to 0x100, results for 2,3 -> commits 0,1, pcg_pc = 0x100, epoch -> 1, entries 2,3 never written back.
REQ-037 Stale result: after flush, FU returns old tag {0,2} -> dropped; new dispatch gets {1,0}.
REQ-038 Trap: tag 0 pc 0x80, rd 3, trap cause 2 -> trap_valid pulse, trap_pc = 0x80, trap_cause = 2, no wb to x3.
REQ-039 Backpressure: wb_ready = 0 for 3 cycles with done head -> wb_valid held, data stable, commit on 4th cycle.
